// File: rtl/map_switch_ctrl_pkg.sv
// Shared types and helpers for the mapper-switch sequencer.
package map_switch_ctrl_pkg;

    localparam int unsigned MSW_ST_W = 3;

    typedef enum logic [MSW_ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BLANK = 3'd2,
        ST_CRST  = 3'd3,
        ST_REL   = 3'd4
    } msw_state_e;

    // Largest of three phase lengths; sizes the shared counter width.
    function automatic int unsigned msw_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/map_sw_cnt.sv
// Loadable saturating down-counter with a zero flag, used for phase and timeout timing.
module map_sw_cnt
    import map_switch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement stops at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/map_switch_ctrl.sv
// Sequences a safe runtime change of the active mapper core: wait for a quiet
// bus, blank outputs, switch sel_idx, pulse the new core's reset, then release.
module map_switch_ctrl
    import map_switch_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned RST_IDX     = 0,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned MAP_RST_CYC = 8,
    parameter int unsigned IDLE_TMO    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cfg_valid,
    input  logic [IDX_W-1:0] i_map_idx_req,
    input  logic             i_bus_idle,
    input  logic             i_ss_act,
    output logic [IDX_W-1:0] o_sel_idx,
    output logic             o_out_blank,
    output logic             o_map_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err_tmo
);

    localparam int unsigned CNT_W =
        $clog2(msw_max3(BLANK_CYC, MAP_RST_CYC, IDLE_TMO) + 1);

    // Counters reach zero on the last clock of each phase, so load length-1.
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CRST_LD  = CNT_W'(MAP_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(IDLE_TMO - 1);

    msw_state_e       r_state;
    logic [IDX_W-1:0] r_sel_idx;
    logic [IDX_W-1:0] r_pend_idx;
    logic [IDX_W-1:0] r_next_idx;
    logic             r_next_pend;
    logic             r_idle_run;
    logic             r_out_blank;
    logic             r_map_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_err_tmo;

    msw_state_e       w_nxt_state;
    logic [IDX_W-1:0] w_nxt_sel_idx;
    logic [IDX_W-1:0] w_nxt_pend_idx;
    logic [IDX_W-1:0] w_nxt_next_idx;
    logic             w_nxt_next_pend;
    logic             w_nxt_idle_run;
    logic             w_nxt_out_blank;
    logic             w_nxt_map_rst;
    logic             w_nxt_busy;
    logic             w_nxt_done;
    logic             w_nxt_err_tmo;

    logic             w_req_valid;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_bus_quiet;
    logic             w_ph_load;
    logic [CNT_W-1:0] w_ph_ld_val;
    logic             w_ph_dec;
    logic             w_ph_zero;
    logic             w_tmo_load;
    logic             w_tmo_dec;
    logic             w_tmo_zero;

    // A fresh strobe overrides a request parked while the previous sequence ran.
    assign w_req_valid = i_cfg_valid | r_next_pend;
    assign w_req_idx   = i_cfg_valid ? i_map_idx_req : r_next_idx;
    assign w_bus_quiet = i_bus_idle & r_idle_run;

    map_sw_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_ld_val),
        .i_dec      (w_ph_dec),
        .o_zero_c   (w_ph_zero)
    );

    map_sw_cnt #(.CNT_W(CNT_W)) u_tmo_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmo_load),
        .i_load_val (TMO_LD),
        .i_dec      (w_tmo_dec),
        .o_zero_c   (w_tmo_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel_idx   <= IDX_W'(RST_IDX);
            r_pend_idx  <= '0;
            r_next_idx  <= '0;
            r_next_pend <= 1'b0;
            r_idle_run  <= 1'b0;
            r_out_blank <= 1'b0;
            r_map_rst   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_sel_idx   <= w_nxt_sel_idx;
            r_pend_idx  <= w_nxt_pend_idx;
            r_next_idx  <= w_nxt_next_idx;
            r_next_pend <= w_nxt_next_pend;
            r_idle_run  <= w_nxt_idle_run;
            r_out_blank <= w_nxt_out_blank;
            r_map_rst   <= w_nxt_map_rst;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_err_tmo   <= w_nxt_err_tmo;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_sel_idx   = r_sel_idx;
        w_nxt_pend_idx  = r_pend_idx;
        w_nxt_next_idx  = r_next_idx;
        w_nxt_next_pend = r_next_pend;
        w_nxt_idle_run  = 1'b0;
        w_nxt_out_blank = r_out_blank;
        w_nxt_map_rst   = r_map_rst;
        w_nxt_busy      = r_busy;
        w_nxt_done      = 1'b0;
        w_nxt_err_tmo   = r_err_tmo;
        w_ph_load       = 1'b0;
        w_ph_ld_val     = BLANK_LD;
        w_ph_dec        = 1'b0;
        w_tmo_load      = 1'b0;
        w_tmo_dec       = 1'b0;

        // Requests arriving mid-sequence are parked; the latest one wins.
        if (i_cfg_valid && (r_state != ST_IDLE)) begin
            w_nxt_next_idx  = i_map_idx_req;
            w_nxt_next_pend = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req_valid) begin
                    w_nxt_pend_idx  = w_req_idx;
                    w_nxt_next_pend = 1'b0;
                    w_nxt_err_tmo   = 1'b0;
                    if (w_req_idx == r_sel_idx) begin
                        w_nxt_done = 1'b1;
                    end else begin
                        w_nxt_state = ST_WAIT;
                        w_nxt_busy  = 1'b1;
                        w_tmo_load  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_nxt_idle_run = i_bus_idle;
                // Save-state activity freezes both the switch and the timeout.
                if (!i_ss_act) begin
                    if (w_bus_quiet || w_tmo_zero) begin
                        w_nxt_state     = ST_BLANK;
                        w_nxt_out_blank = 1'b1;
                        w_nxt_sel_idx   = r_pend_idx;
                        w_nxt_err_tmo   = ~w_bus_quiet;
                        w_ph_load       = 1'b1;
                        w_ph_ld_val     = BLANK_LD;
                    end else begin
                        w_tmo_dec = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (w_ph_zero) begin
                    w_nxt_state   = ST_CRST;
                    w_nxt_map_rst = 1'b1;
                    w_ph_load     = 1'b1;
                    w_ph_ld_val   = CRST_LD;
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            ST_CRST: begin
                if (w_ph_zero) begin
                    w_nxt_state   = ST_REL;
                    w_nxt_map_rst = 1'b0;
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            ST_REL: begin
                w_nxt_state     = ST_IDLE;
                w_nxt_out_blank = 1'b0;
                w_nxt_busy      = 1'b0;
                w_nxt_done      = 1'b1;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    assign o_sel_idx   = r_sel_idx;
    assign o_out_blank = r_out_blank;
    assign o_map_rst   = r_map_rst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_map_switch_ctrl.sv
// Self-checking bench for map_switch_ctrl: directed scenarios plus randomized
// requests/bus patterns checked against a transaction-level timing model.
module tb_map_switch_ctrl;

    localparam int unsigned IDX_W       = 8;
    localparam int unsigned RST_IDX     = 0;
    localparam int unsigned BLANK_CYC   = 16;
    localparam int unsigned MAP_RST_CYC = 8;
    localparam int unsigned IDLE_TMO    = 1024;
    localparam int          SEQ_TAIL    = BLANK_CYC + MAP_RST_CYC + 1;
    localparam int          PAT_N       = 1400;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_cfg_valid;
    logic [IDX_W-1:0] i_map_idx_req;
    logic             i_bus_idle;
    logic             i_ss_act;
    logic [IDX_W-1:0] o_sel_idx;
    logic             o_out_blank;
    logic             o_map_rst;
    logic             o_busy;
    logic             o_done;
    logic             o_err_tmo;

    map_switch_ctrl #(
        .IDX_W       (IDX_W),
        .RST_IDX     (RST_IDX),
        .BLANK_CYC   (BLANK_CYC),
        .MAP_RST_CYC (MAP_RST_CYC),
        .IDLE_TMO    (IDLE_TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cfg_valid   (i_cfg_valid),
        .i_map_idx_req (i_map_idx_req),
        .i_bus_idle    (i_bus_idle),
        .i_ss_act      (i_ss_act),
        .o_sel_idx     (o_sel_idx),
        .o_out_blank   (o_out_blank),
        .o_map_rst     (o_map_rst),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err_tmo     (o_err_tmo)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic bus_pat [PAT_N];

    int         m_lat, m_blank, m_rst, m_busy, m_first_blank, m_start;
    logic [7:0] m_sel_at_blank, m_sel_done;
    logic       m_err_done, m_busy_done, m_done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle k drives bus_pat[k], which the DUT samples at clock edge k.
    task automatic step();
        i_bus_idle = bus_pat[(cyc < PAT_N) ? cyc : PAT_N - 1];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] idx);
        cyc           = 0;
        i_cfg_valid   = 1'b1;
        i_map_idx_req = idx;
        step();
        i_cfg_valid   = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] idx);
        i_cfg_valid   = 1'b1;
        i_map_idx_req = idx;
        step();
        i_cfg_valid   = 1'b0;
    endtask

    task automatic fill_pat(input logic v);
        for (int k = 0; k < PAT_N; k++) bus_pat[k] = v;
    endtask

    task automatic wait_done(input string tag, input int limit);
        m_blank = 0; m_rst = 0; m_busy = 0; m_first_blank = -1; m_lat = -1;
        m_sel_at_blank = '0; m_sel_done = '0; m_err_done = 1'b0; m_busy_done = 1'b0;
        m_done_seen = 1'b0;
        m_start = cyc;
        while (cyc <= limit) begin
            if (o_out_blank) begin
                if (m_blank == 0) begin
                    m_first_blank  = cyc;
                    m_sel_at_blank = o_sel_idx;
                end
                m_blank++;
            end
            if (o_map_rst) m_rst++;
            if (o_busy) m_busy++;
            if (o_done) begin
                m_done_seen = 1'b1;
                m_lat       = cyc;
                m_sel_done  = o_sel_idx;
                m_err_done  = o_err_tmo;
                m_busy_done = o_busy;
                break;
            end
            step();
        end
        chk({tag, "_done_seen"}, 32'(m_done_seen), 32'(1));
    endtask

    // Expected first edge that sees two consecutive idle samples, or -1 on timeout.
    function automatic int exp_edge();
        for (int e = 2; e <= int'(IDLE_TMO); e++)
            if (bus_pat[e-1] && bus_pat[e]) return e;
        return -1;
    endfunction

    // Full switch: blank starts at fb and lasts SEQ_TAIL clocks, done follows.
    task automatic check_full(input string tag, input logic [7:0] idx, input int fb, input logic tmo);
        chk({tag, "_blank_entry"}, 32'(m_first_blank), 32'(fb));
        chk({tag, "_sel_at_blank"}, 32'(m_sel_at_blank), 32'(idx));
        chk({tag, "_latency"}, 32'(m_lat), 32'(fb + SEQ_TAIL));
        chk({tag, "_blank_clks"}, 32'(m_blank), 32'(SEQ_TAIL));
        chk({tag, "_maprst_clks"}, 32'(m_rst), 32'(MAP_RST_CYC));
        chk({tag, "_busy_clks"}, 32'(m_busy), 32'(fb + SEQ_TAIL - m_start));
        chk({tag, "_sel_done"}, 32'(m_sel_done), 32'(idx));
        chk({tag, "_err_tmo"}, 32'(m_err_done), 32'(tmo));
        chk({tag, "_busy_at_done"}, 32'(m_busy_done), 32'(0));
    endtask

    task automatic check_same(input string tag, input logic [7:0] idx);
        chk({tag, "_latency"}, 32'(m_lat), 32'(1));
        chk({tag, "_blank_clks"}, 32'(m_blank), 32'(0));
        chk({tag, "_maprst_clks"}, 32'(m_rst), 32'(0));
        chk({tag, "_busy_clks"}, 32'(m_busy), 32'(0));
        chk({tag, "_sel_done"}, 32'(m_sel_done), 32'(idx));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sel"}, 32'(o_sel_idx), 32'(RST_IDX));
        chk({tag, "_blank"}, 32'(o_out_blank), 32'(0));
        chk({tag, "_maprst"}, 32'(o_map_rst), 32'(0));
        chk({tag, "_busy"}, 32'(o_busy), 32'(0));
        chk({tag, "_done"}, 32'(o_done), 32'(0));
        chk({tag, "_err"}, 32'(o_err_tmo), 32'(0));
    endtask

    task automatic done_gone(input string tag);
        step();
        chk({tag, "_done_width"}, 32'(o_done), 32'(0));
    endtask

    initial begin
        logic [7:0] exp_sel;
        logic [7:0] idx;
        int         e;
        int         extra_done;

        rst_n         = 1'b0;
        i_cfg_valid   = 1'b0;
        i_map_idx_req = '0;
        i_bus_idle    = 1'b0;
        i_ss_act      = 1'b0;
        fill_pat(1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Request for the already-selected core completes without blanking.
        send(8'(RST_IDX));
        wait_done("t2", 10);
        check_same("t2", 8'(RST_IDX));
        done_gone("t2");

        // Full switch with an idle bus.
        send(8'd254);
        wait_done("t1", 100);
        check_full("t1", 8'd254, 3, 1'b0);
        done_gone("t1");

        // Bus idle pattern 1,0,1,1: only the final pair releases WAIT.
        fill_pat(1'b1);
        bus_pat[1] = 1'b1; bus_pat[2] = 1'b0; bus_pat[3] = 1'b1; bus_pat[4] = 1'b1;
        send(8'd100);
        wait_done("t5", 100);
        check_full("t5", 8'd100, exp_edge() + 1, 1'b0);
        done_gone("t5");

        // Bus never idle: forced switch after IDLE_TMO waiting clocks.
        fill_pat(1'b0);
        send(8'd33);
        wait_done("t3", 1300);
        check_full("t3", 8'd33, int'(IDLE_TMO) + 1, 1'b1);
        done_gone("t3");
        chk("t3_err_sticky", 32'(o_err_tmo), 32'(1));

        // Save-state active: no timeout and no switch; resumes when it drops.
        for (int k = 0; k < PAT_N; k++) bus_pat[k] = (k >= 1100);
        i_ss_act = 1'b1;
        send(8'd44);
        chk("t3b_err_cleared", 32'(o_err_tmo), 32'(0));
        while (cyc < 1100) step();
        chk("t3b_busy_held", 32'(o_busy), 32'(1));
        chk("t3b_no_blank", 32'(o_out_blank), 32'(0));
        chk("t3b_sel_kept", 32'(o_sel_idx), 32'(33));
        chk("t3b_no_tmo", 32'(o_err_tmo), 32'(0));
        i_ss_act = 1'b0;
        wait_done("t3b", 1400);
        // Idle pair sampled at edges 1100/1101 with ss_act low -> blank from 1102.
        check_full("t3b", 8'd44, 1102, 1'b0);
        done_gone("t3b");

        // Requests while busy: 7 then 9 parked, last one wins; ss_act in BLANK ignored.
        fill_pat(1'b1);
        send(8'd5);
        while (cyc < 2) step();
        pulse(8'd7);
        while (cyc < 10) step();
        i_ss_act = 1'b1;
        while (cyc < 20) step();
        i_ss_act = 1'b0;
        pulse(8'd9);
        wait_done("t4a", 100);
        chk("t4a_latency", 32'(m_lat), 32'(28));
        chk("t4a_sel_done", 32'(m_sel_done), 32'(5));
        chk("t4a_busy_at_done", 32'(m_busy_done), 32'(0));
        step();
        chk("t4_next_started", 32'(o_busy), 32'(1));
        chk("t4_done_width", 32'(o_done), 32'(0));
        wait_done("t4b", 200);
        check_full("t4b", 8'd9, 31, 1'b0);
        extra_done = 0;
        repeat (6) begin
            step();
            if (o_done || o_busy) extra_done++;
        end
        chk("t4_no_third_seq", 32'(extra_done), 32'(0));

        // Asynchronous reset in CORE_RST, then a normal request.
        send(8'd77);
        while (cyc < 22) step();
        chk("t6_in_core_rst", 32'(o_map_rst), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_idle_after", 32'(o_busy), 32'(0));
        send(8'd78);
        wait_done("t6", 100);
        check_full("t6", 8'd78, 3, 1'b0);
        exp_sel = 8'd78;

        // Randomized requests, each issued in the done cycle of the previous one.
        for (int it = 0; it < 10; it++) begin
            idx = (it == 3) ? exp_sel : 8'($urandom);
            for (int k = 0; k < PAT_N; k++) bus_pat[k] = 1'($urandom_range(0, 1));
            send(idx);
            wait_done($sformatf("rnd%0d", it), 1300);
            if (idx == exp_sel) begin
                check_same($sformatf("rnd%0d", it), idx);
            end else begin
                e = exp_edge();
                if (e < 0) check_full($sformatf("rnd%0d", it), idx, int'(IDLE_TMO) + 1, 1'b1);
                else       check_full($sformatf("rnd%0d", it), idx, e + 1, 1'b0);
                exp_sel = idx;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
